// File: rtl/dht_report_pkg.sv
// Shared constants for the DHT report sequencer: frame geometry, ASCII
// characters, field positions inside the report line and the FSM encoding.
package dht_report_pkg;

  localparam int         FRAME_LEN = 25;
  localparam logic [4:0] LAST_IDX  = 5'(FRAME_LEN - 1);

  localparam logic [7:0] CH_T       = 8'h74;
  localparam logic [7:0] CH_E       = 8'h65;
  localparam logic [7:0] CH_M       = 8'h6D;
  localparam logic [7:0] CH_P       = 8'h70;
  localparam logic [7:0] CH_H       = 8'h68;
  localparam logic [7:0] CH_U       = 8'h75;
  localparam logic [7:0] CH_I       = 8'h69;
  localparam logic [7:0] CH_COLON   = 8'h3A;
  localparam logic [7:0] CH_SP      = 8'h20;
  localparam logic [7:0] CH_DOT     = 8'h2E;
  localparam logic [7:0] CH_TAB     = 8'h09;
  localparam logic [7:0] CH_LF      = 8'h0A;
  localparam logic [7:0] CH_O       = 8'h4F;
  localparam logic [7:0] CH_K       = 8'h4B;
  localparam logic [7:0] CH_X       = 8'h58;
  localparam logic [7:0] CH_QMARK   = 8'h3F;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // Positions of the variable fields; the fixed labels fill the gaps.
  localparam logic [4:0] IDX_T10   = 5'd6;
  localparam logic [4:0] IDX_T0    = 5'd7;
  localparam logic [4:0] IDX_TDOT  = 5'd8;
  localparam logic [4:0] IDX_TMIN  = 5'd9;
  localparam logic [4:0] IDX_TSP   = 5'd10;
  localparam logic [4:0] IDX_H10   = 5'd17;
  localparam logic [4:0] IDX_H0    = 5'd18;
  localparam logic [4:0] IDX_HDOT  = 5'd19;
  localparam logic [4:0] IDX_HMIN  = 5'd20;
  localparam logic [4:0] IDX_TAB   = 5'd21;
  localparam logic [4:0] IDX_STAT0 = 5'd22;
  localparam logic [4:0] IDX_STAT1 = 5'd23;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/dht_report_sequencer_bcd_to_ascii.sv
// BCD digit to printable ASCII; non-decimal codes are shown as '?' so a
// corrupted reading is visible on the terminal rather than garbage.
module bcd_to_ascii
  import dht_report_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] ascii
);

  assign ascii = (digit <= 4'd9) ? (ASCII_ZERO + {4'h0, digit}) : CH_QMARK;

endmodule

// File: rtl/dht_report_sequencer.sv
// Formats one DHT measurement into a 25-byte ASCII report line and pushes it
// into the UART TX FIFO byte by byte under push/full flow control.
module dht_report_sequencer
  import dht_report_pkg::*;
#(
  parameter int PERIOD_TICKS = 100,
  parameter int CNT_W        = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_auto_en,
  input  logic       i_dht_done,
  input  logic       i_error,
  input  logic [3:0] i_temp10,
  input  logic [3:0] i_temp0,
  input  logic [3:0] i_temp_min,
  input  logic [3:0] i_humi10,
  input  logic [3:0] i_humi0,
  input  logic [3:0] i_humi_min,
  input  logic       i_tx_full,
  output logic       o_tx_push,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_frame_done
);

  state_t           state, state_n;
  logic [4:0]       idx, idx_n;
  logic             pending, pending_n;
  logic             load_snap;
  logic             frame_done_q, frame_done_n;
  logic [CNT_W-1:0] period_cnt;
  logic             period_wrap;
  logic             req;
  logic             push;

  logic [3:0] snap_t10, snap_t0, snap_tmin;
  logic [3:0] snap_h10, snap_h0, snap_hmin;
  logic       snap_err;
  logic [7:0] asc_t10, asc_t0, asc_tmin;
  logic [7:0] asc_h10, asc_h0, asc_hmin;
  logic [7:0] tx_char;

  assign period_wrap = i_tick && (period_cnt == CNT_W'(PERIOD_TICKS - 1));
  assign req         = i_dht_done | (period_wrap & i_auto_en);
  assign push        = (state == ST_SEND) && !i_tx_full;

  // Free-running report timer; keeps counting while a frame is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (i_tick) begin
      period_cnt <= period_wrap ? '0 : period_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    pending_n    = pending;
    load_snap    = 1'b0;
    frame_done_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req || pending) begin
          load_snap = 1'b1;
          idx_n     = 5'd0;
          pending_n = 1'b0;
          state_n   = ST_SEND;
        end
      end
      ST_SEND: begin
        // Only one request is remembered while busy; extras are dropped.
        if (req) begin
          pending_n = 1'b1;
        end
        if (push) begin
          if (idx == LAST_IDX) begin
            idx_n        = 5'd0;
            state_n      = ST_IDLE;
            frame_done_n = 1'b1;
          end else begin
            idx_n = idx + 5'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= 5'd0;
      pending      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      pending      <= pending_n;
      frame_done_q <= frame_done_n;
    end
  end

  // Snapshot at frame start so a frame never mixes two measurements.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_t10  <= '0;
      snap_t0   <= '0;
      snap_tmin <= '0;
      snap_h10  <= '0;
      snap_h0   <= '0;
      snap_hmin <= '0;
      snap_err  <= 1'b0;
    end else if (load_snap) begin
      snap_t10  <= i_temp10;
      snap_t0   <= i_temp0;
      snap_tmin <= i_temp_min;
      snap_h10  <= i_humi10;
      snap_h0   <= i_humi0;
      snap_hmin <= i_humi_min;
      snap_err  <= i_error;
    end
  end

  bcd_to_ascii u_t10  (.digit(snap_t10),  .ascii(asc_t10));
  bcd_to_ascii u_t0   (.digit(snap_t0),   .ascii(asc_t0));
  bcd_to_ascii u_tmin (.digit(snap_tmin), .ascii(asc_tmin));
  bcd_to_ascii u_h10  (.digit(snap_h10),  .ascii(asc_h10));
  bcd_to_ascii u_h0   (.digit(snap_h0),   .ascii(asc_h0));
  bcd_to_ascii u_hmin (.digit(snap_hmin), .ascii(asc_hmin));

  always_comb begin
    tx_char = CH_QMARK;
    case (idx)
      5'd0:      tx_char = CH_T;
      5'd1:      tx_char = CH_E;
      5'd2:      tx_char = CH_M;
      5'd3:      tx_char = CH_P;
      5'd4:      tx_char = CH_COLON;
      5'd5:      tx_char = CH_SP;
      IDX_T10:   tx_char = asc_t10;
      IDX_T0:    tx_char = asc_t0;
      IDX_TDOT:  tx_char = CH_DOT;
      IDX_TMIN:  tx_char = asc_tmin;
      IDX_TSP:   tx_char = CH_SP;
      5'd11:     tx_char = CH_H;
      5'd12:     tx_char = CH_U;
      5'd13:     tx_char = CH_M;
      5'd14:     tx_char = CH_I;
      5'd15:     tx_char = CH_COLON;
      5'd16:     tx_char = CH_SP;
      IDX_H10:   tx_char = asc_h10;
      IDX_H0:    tx_char = asc_h0;
      IDX_HDOT:  tx_char = CH_DOT;
      IDX_HMIN:  tx_char = asc_hmin;
      IDX_TAB:   tx_char = CH_TAB;
      IDX_STAT0: tx_char = snap_err ? CH_X : CH_O;
      IDX_STAT1: tx_char = snap_err ? CH_X : CH_K;
      LAST_IDX:  tx_char = CH_LF;
      default:   tx_char = CH_QMARK;
    endcase
  end

  // Push is masked by rst so an aborted frame emits nothing in that cycle.
  assign o_tx_push    = push && !rst;
  assign o_tx_data    = tx_char;
  assign o_busy       = (state == ST_SEND);
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_dht_report_sequencer.sv
// Randomised plus directed bench for dht_report_sequencer, checked every cycle
// against a queue-of-expected-bytes reference model.
module tb_dht_report_sequencer;

  localparam int PERIOD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_tick = 1'b0, i_auto_en = 1'b0, i_dht_done = 1'b0, i_error = 1'b0;
  logic [3:0] i_temp10 = '0, i_temp0 = '0, i_temp_min = '0;
  logic [3:0] i_humi10 = '0, i_humi0 = '0, i_humi_min = '0;
  logic       i_tx_full = 1'b0;
  logic       o_tx_push, o_busy, o_frame_done;
  logic [7:0] o_tx_data;

  always #5 clk = ~clk;

  dht_report_sequencer #(.PERIOD_TICKS(PERIOD), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_auto_en(i_auto_en),
    .i_dht_done(i_dht_done), .i_error(i_error),
    .i_temp10(i_temp10), .i_temp0(i_temp0), .i_temp_min(i_temp_min),
    .i_humi10(i_humi10), .i_humi0(i_humi0), .i_humi_min(i_humi_min),
    .i_tx_full(i_tx_full), .o_tx_push(o_tx_push), .o_tx_data(o_tx_data),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  int total = 0;
  int bad = 0;

  // Reference model state: bytes still owed by the current frame.
  logic [7:0] exp_q[$];
  bit         pend = 0;
  int         tick_cnt = 0;
  bit         done_flag = 0;

  // Capture of what the DUT actually pushed, for directed checks.
  logic [7:0] cap[$];
  int         push_cyc[$];
  int         fd_cnt = 0;
  int         fd_cyc = 0;
  int         done_cyc = 0;
  int         cyc = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic string digitStr(input logic [3:0] d);
    if (d <= 4'd9) return $sformatf("%0d", d);
    return "?";
  endfunction

  function automatic string frameStr();
    return {"temp: ", digitStr(i_temp10), digitStr(i_temp0), ".", digitStr(i_temp_min),
            " humi: ", digitStr(i_humi10), digitStr(i_humi0), ".", digitStr(i_humi_min),
            "\t", (i_error ? "XX" : "OK"), "\n"};
  endfunction

  // Compare outputs with the model for this cycle, then advance the model.
  task automatic modelStep();
    bit    in_frame;
    bit    req;
    bit    auto_req;
    string s;
    cyc++;
    in_frame = (exp_q.size() > 0);
    checkOutput("busy", o_busy, in_frame);
    checkOutput("push", o_tx_push, in_frame && !i_tx_full && !rst);
    checkOutput("frame_done", o_frame_done, done_flag);
    if (!in_frame) checkOutput("idle_data", o_tx_data, 8'h74);
    else if (!rst) checkOutput("data", o_tx_data, exp_q[0]);
    if (o_tx_push) begin
      cap.push_back(o_tx_data);
      push_cyc.push_back(cyc);
    end
    if (o_frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (i_dht_done) done_cyc = cyc;

    if (rst) begin
      exp_q.delete();
      pend = 0;
      tick_cnt = 0;
      done_flag = 0;
    end else begin
      auto_req = 0;
      if (i_tick) begin
        tick_cnt++;
        if (tick_cnt == PERIOD) begin
          tick_cnt = 0;
          auto_req = i_auto_en;
        end
      end
      req = i_dht_done || auto_req;
      done_flag = 0;
      if (in_frame) begin
        if (req) pend = 1;
        if (!i_tx_full) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) done_flag = 1;
        end
      end else if (req || pend) begin
        s = frameStr();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        pend = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic done_v, input logic tick_v, input logic full_v);
    i_dht_done = done_v;
    i_tick     = tick_v;
    i_tx_full  = full_v;
    @(negedge clk);
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic runIdle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic clearCapture();
    cap.delete();
    push_cyc.delete();
    fd_cnt = 0;
  endtask

  task automatic setDigits(input int t10, input int t0, input int tm, input int h10, input int h0, input int hm);
    i_temp10 = 4'(t10); i_temp0 = 4'(t0); i_temp_min = 4'(tm);
    i_humi10 = 4'(h10); i_humi0 = 4'(h0); i_humi_min = 4'(hm);
  endtask

  initial begin
    string ref_s;
    string sub_s;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_busy", o_busy, 1'b0);
    checkOutput("rst_push", o_tx_push, 1'b0);
    checkOutput("rst_fdone", o_frame_done, 1'b0);
    checkOutput("rst_data", o_tx_data, 8'h74);
    rst = 1'b0;
    runIdle(3);

    // Basic frame, no backpressure
    setDigits(2, 5, 3, 6, 1, 7);
    clearCapture();
    applyStimulus(1'b1, 1'b0, 1'b0);
    runIdle(30);
    ref_s = "temp: 25.3 humi: 61.7\tOK\n";
    checkOutput("t1_count", cap.size(), 25);
    checkOutput("t1_fdcnt", fd_cnt, 1);
    if (cap.size() == 25) begin
      for (int i = 0; i < 25; i++) checkOutput("t1_text", cap[i], ref_s[i]);
      checkOutput("t1_first_lat", push_cyc[0] - done_cyc, 1);
      checkOutput("t1_span", push_cyc[24] - push_cyc[0], 24);
      checkOutput("t1_fd_after_last", fd_cyc - push_cyc[24], 1);
      checkOutput("t1_fd_lat", fd_cyc - done_cyc, 26);
    end

    // Error flag captured at request, dropped mid-frame
    clearCapture();
    i_error = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    i_error = 1'b0;
    runIdle(30);
    checkOutput("t2_count", cap.size(), 25);
    if (cap.size() == 25) begin
      checkOutput("t2_stat0", cap[22], 8'h58);
      checkOutput("t2_stat1", cap[23], 8'h58);
    end

    // Backpressure for 3 cycles at idx 8
    clearCapture();
    ref_s = frameStr();
    applyStimulus(1'b1, 1'b0, 1'b0);
    runIdle(8);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    runIdle(25);
    checkOutput("t3_count", cap.size(), 25);
    if (cap.size() == 25) begin
      for (int i = 0; i < 25; i++) checkOutput("t3_text", cap[i], ref_s[i]);
      checkOutput("t3_dot", cap[8], 8'h2E);
      checkOutput("t3_stall_gap", push_cyc[8] - push_cyc[7], 4);
      checkOutput("t3_span", push_cyc[24] - push_cyc[0] + 1, 28);
    end

    // Pending request: two extra pulses during SEND, digits changed to 3,0,0
    clearCapture();
    applyStimulus(1'b1, 1'b0, 1'b0);
    runIdle(4);
    setDigits(3, 0, 0, 6, 1, 7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runIdle(3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runIdle(60);
    checkOutput("t4_count", cap.size(), 50);
    checkOutput("t4_fdcnt", fd_cnt, 2);
    if (cap.size() == 50) begin
      sub_s = "25.330.0";
      for (int i = 0; i < 4; i++) checkOutput("t4_first_digits", cap[6 + i], sub_s[i]);
      for (int i = 0; i < 4; i++) checkOutput("t4_second_digits", cap[31 + i], sub_s[4 + i]);
      checkOutput("t4_gap", push_cyc[25] - push_cyc[24], 2);
    end

    // Reset in the middle of a frame at idx 12
    clearCapture();
    applyStimulus(1'b1, 1'b0, 1'b0);
    runIdle(12);
    checkOutput("t7_pre_count", cap.size(), 12);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("t7_busy", o_busy, 1'b0);
    checkOutput("t7_push", o_tx_push, 1'b0);
    checkOutput("t7_fdone", o_frame_done, 1'b0);
    checkOutput("t7_data", o_tx_data, 8'h74);
    checkOutput("t7_rst_count", cap.size(), 12);
    clearCapture();
    applyStimulus(1'b1, 1'b0, 1'b0);
    runIdle(30);
    checkOutput("t7_count", cap.size(), 25);
    if (cap.size() > 0) checkOutput("t7_first", cap[0], 8'h74);

    // Auto reports: done coincident with 4th tick gives a single frame
    i_auto_en = 1'b1;
    clearCapture();
    for (int k = 1; k <= 4; k++) begin
      runIdle(9);
      applyStimulus(k == 4, 1'b1, 1'b0);
    end
    runIdle(35);
    checkOutput("t5_count", cap.size(), 25);
    checkOutput("t5_fdcnt", fd_cnt, 1);
    i_auto_en = 1'b0;
    clearCapture();
    repeat (8) begin
      runIdle(9);
      applyStimulus(1'b0, 1'b1, 1'b0);
    end
    runIdle(5);
    checkOutput("t5_noauto", cap.size(), 0);
    i_auto_en = 1'b1;
    clearCapture();
    repeat (4) begin
      runIdle(9);
      applyStimulus(1'b0, 1'b1, 1'b0);
    end
    runIdle(30);
    checkOutput("t5_autoonly", cap.size(), 25);

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      setDigits($urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0),
                $urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0));
      i_error   = ($urandom_range(3, 0) == 0);
      i_auto_en = ($urandom_range(1, 0) == 1);
      rst       = ($urandom_range(299, 0) == 0);
      applyStimulus($urandom_range(19, 0) == 0, $urandom_range(4, 0) == 0, $urandom_range(3, 0) == 0);
    end
    rst = 1'b0;
    i_auto_en = 1'b0;
    runIdle(60);
    checkOutput("end_idle", o_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
